collision_response: RTL

//  Reacts to the debounced colDetect flag from the collision detector and drives the motor controller.

---
 rtl/collision_response.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/collision_response.sv
// Collision response controller: drives the motor through DRIVE, then BRAKE/BACKOFF/SETTLE after a hit,
// and latches a sticky FAULT after repeated hits or when both sides are blocked.
module collision_response #(
  parameter int BRAKE_CYCLES   = 25000,
  parameter int BACKOFF_CYCLES = 100000,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       driveReq,
  input  logic       cmdDir,
  input  logic       colDetect,
  input  logic       clrFault,
  output logic       motorEn,
  output logic       motorDir,
  output logic       direction,
  output logic       colAck,
  output logic       fault,
  output logic [2:0] stateOut
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    BRAKE   = 3'd2,
    BACKOFF = 3'd3,
    SETTLE  = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] BRAKE_LOAD   = CNT_W'(BRAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BACKOFF_LOAD = CNT_W'(BACKOFF_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t           state, state_nx;
  logic             cur_dir, cur_dir_nx;
  logic             rev_flag, rev_flag_nx;
  logic [CNT_W-1:0] timer, timer_nx;
  logic [3:0]       retry_cnt, retry_nx;
  logic             col_ack_nx;
  logic             dir_nx;

  always_comb begin
    state_nx    = state;
    cur_dir_nx  = cur_dir;
    rev_flag_nx = rev_flag;
    timer_nx    = timer;
    retry_nx    = retry_cnt;
    col_ack_nx  = 1'b0;
    case (state)
      IDLE: begin
        retry_nx = '0;
        if (driveReq) begin
          cur_dir_nx = cmdDir;
          state_nx   = DRIVE;
        end
      end
      DRIVE: begin
        if (colDetect) begin
          state_nx    = BRAKE;
          col_ack_nx  = 1'b1;
          rev_flag_nx = 1'b0;
          timer_nx    = BRAKE_LOAD;
          if (retry_cnt != 4'hF) retry_nx = retry_cnt + 4'd1;
        end else if (!driveReq) begin
          state_nx = IDLE;
        end else if (cmdDir != cur_dir) begin
          state_nx    = BRAKE;
          rev_flag_nx = 1'b1;
          timer_nx    = BRAKE_LOAD;
        end
      end
      BRAKE: begin
        if (timer == '0) begin
          if (rev_flag) begin
            state_nx   = DRIVE;
            cur_dir_nx = cmdDir;
          end else if (retry_cnt >= RETRY_LIMIT) begin
            state_nx = FAULT;
          end else begin
            state_nx = BACKOFF;
            timer_nx = BACKOFF_LOAD;
          end
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      BACKOFF: begin
        // A hit while reversing means both sides are blocked.
        if (colDetect) state_nx = FAULT;
        else if (timer == '0) state_nx = SETTLE;
        else timer_nx = timer - 1'b1;
      end
      SETTLE: begin
        if (!driveReq) begin
          state_nx = IDLE;
        end else if (!colDetect) begin
          state_nx   = DRIVE;
          cur_dir_nx = cmdDir;
        end
      end
      FAULT: begin
        if (clrFault && !colDetect) begin
          state_nx = IDLE;
          retry_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with stateOut.
  assign dir_nx = (state_nx == BACKOFF) ? ~cur_dir_nx : cur_dir_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_dir   <= 1'b0;
      rev_flag  <= 1'b0;
      timer     <= '0;
      retry_cnt <= '0;
      motorEn   <= 1'b0;
      motorDir  <= 1'b0;
      direction <= 1'b0;
      colAck    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nx;
      cur_dir   <= cur_dir_nx;
      rev_flag  <= rev_flag_nx;
      timer     <= timer_nx;
      retry_cnt <= retry_nx;
      motorEn   <= (state_nx == DRIVE) || (state_nx == BACKOFF);
      motorDir  <= dir_nx;
      direction <= dir_nx;
      colAck    <= col_ack_nx;
      fault     <= (state_nx == FAULT);
    end
  end

  assign stateOut = state;

endmodule
